rect_pos_ctl: RTL

RECT_POS_CTL -- requirements
Module: rect_pos_ctl

---
 rtl/rect_pos_ctl.sv | 111 +++++++++++
 1 files changed

// File: rtl/rect_pos_ctl.sv
// rect_pos_ctl: frame-synchronous rectangle position register, loaded once per vblank rise.
// Define RECT_BOUNCE_EN to compile in autonomous bounce mode (mode=1); otherwise follow mode only.
module rect_pos_ctl #(
    parameter int W     = 48,
    parameter int H     = 64,
    parameter int SCR_W = 800,
    parameter int SCR_H = 600,
    parameter int STEP  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic        mode,
    input  logic        req_valid,
    input  logic [11:0] req_x,
    input  logic [11:0] req_y,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        upd
);
    localparam logic [1:0]  ACTIVE = 2'd0;
    localparam logic [1:0]  UPDATE = 2'd1;
    localparam logic [1:0]  BLANK  = 2'd2;
    localparam logic [11:0] XMAX   = 12'(SCR_W - W);
    localparam logic [11:0] YMAX   = 12'(SCR_H - H);

    logic [1:0]  r_state;
    logic        r_vblnk_q;
    logic        r_armed;
    logic [11:0] r_px;
    logic [11:0] r_py;
    logic        w_evt;
    logic [1:0]  w_state_nxt;
    logic [11:0] w_fx;
    logic [11:0] w_fy;
    logic [11:0] w_nx;
    logic [11:0] w_ny;

    // r_armed blocks a frame event until vblnk has been seen low since reset
    assign w_evt = (r_state == ACTIVE) && vblnk && !r_vblnk_q && r_armed;
    assign w_fx  = (r_px > XMAX) ? XMAX : r_px;
    assign w_fy  = (r_py > YMAX) ? YMAX : r_py;

    always_comb begin
        w_state_nxt = (r_state == ACTIVE) ? (w_evt ? UPDATE : ACTIVE) :
                      (r_state == UPDATE) ? BLANK :
                      (r_state == BLANK)  ? (vblnk ? BLANK : ACTIVE) : ACTIVE;
    end

`ifdef RECT_BOUNCE_EN
    logic        r_dx;
    logic        r_dy;
    logic [12:0] w_bx;
    logic [12:0] w_by;

    // returns {next_dir, next_pos}
    function automatic logic [12:0] bounce(input logic [11:0] p, input logic d, input logic [11:0] mx);
        logic [12:0] s;
        s = {1'b0, p} + 13'(STEP);
        if (d && s >= {1'b0, mx}) return {1'b0, mx};
        if (!d && p <= 12'(STEP)) return {1'b1, 12'd0};
        return {d, d ? s[11:0] : p - 12'(STEP)};
    endfunction

    assign w_bx = bounce(x, r_dx, XMAX);
    assign w_by = bounce(y, r_dy, YMAX);
    assign w_nx = mode ? w_bx[11:0] : w_fx;
    assign w_ny = mode ? w_by[11:0] : w_fy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dx <= 1'b1;
            r_dy <= 1'b1;
        end else if (r_state == UPDATE && mode) begin
            r_dx <= w_bx[12];
            r_dy <= w_by[12];
        end
    end
`else
    logic w_unused;
    assign w_unused = mode;
    assign w_nx     = w_fx;
    assign w_ny     = w_fy;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ACTIVE;
            r_vblnk_q <= 1'b0;
            r_armed   <= 1'b0;
            r_px      <= 12'd0;
            r_py      <= 12'd0;
            x         <= 12'd0;
            y         <= 12'd0;
            upd       <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_vblnk_q <= vblnk;
            r_armed   <= r_armed | ~vblnk;
            upd       <= (r_state == UPDATE);
            if (req_valid) begin
                r_px <= req_x;
                r_py <= req_y;
            end
            if (r_state == UPDATE) begin
                x <= w_nx;
                y <= w_ny;
            end
        end
    end
endmodule
